// File: rtl/fft_pkg.sv
// Shared types for the FFT post-processing blocks: bin-stream sample format,
// magnitude width and the peak detector state encoding.
package fft_pkg;

  localparam int NPTS  = 64;
  localparam int ADR_W = 6;

  // Matches the fft_controller wd layout: real in the upper half.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef logic [31:0] mag_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_REPORT   = 3'd3,
    ST_WAIT_LOW = 3'd4,
    ST_ABORT    = 3'd5
  } state_e;

endpackage

// File: rtl/fft_peak_detector_if.sv
// Bin stream in from fft_controller plus the per-frame peak report out.
interface fft_peak_detector_if;
  import fft_pkg::*;

  logic             fft_done;
  cplx_t            fft_wd;
  mag_t             threshold;
  logic [ADR_W-1:0] peak_bin;
  mag_t             peak_mag;
  logic             peak_above;
  logic             peak_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output fft_done, fft_wd, threshold,
    input  peak_bin, peak_mag, peak_above, peak_valid, frame_err, busy
  );

  modport slave (
    input  fft_done, fft_wd, threshold,
    output peak_bin, peak_mag, peak_above, peak_valid, frame_err, busy
  );
endinterface

// File: rtl/fft_mag_sq.sv
// Two-stage re^2 + im^2 pipeline; the bin index rides along with each sample.
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  cplx_t            sample,
  input  logic [ADR_W-1:0] tag_in,
  output logic             out_valid,
  output mag_t             mag,
  output logic [ADR_W-1:0] tag_out
);

  logic signed [31:0] re_w, im_w;
  logic               s1_valid;
  mag_t               s1_re_sq, s1_im_sq;
  logic [ADR_W-1:0]   s1_tag;

  assign re_w = 32'(sample.re);
  assign im_w = 32'(sample.im);

  // Each square is at most 2^30, so the sum tops out at 2^31 and cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_re_sq  <= '0;
      s1_im_sq  <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      mag       <= '0;
      tag_out   <= '0;
    end else begin
      s1_valid  <= in_valid & ~flush;
      s1_re_sq  <= re_w * re_w;
      s1_im_sq  <= im_w * im_w;
      s1_tag    <= tag_in;
      out_valid <= s1_valid & ~flush;
      mag       <= s1_re_sq + s1_im_sq;
      tag_out   <= s1_tag;
    end
  end

endmodule

// File: rtl/fft_peak_detector.sv
// Scans each FFT frame for the strongest bin inside [BIN_LO, BIN_HI] and
// emits one report per frame, or a frame_err pulse if done drops early.
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 31,
  parameter int NPTS   = 64
) (
  input  logic                clk,
  input  logic                reset,
  fft_peak_detector_if.slave  bus
);

  localparam logic [ADR_W-1:0] LO   = ADR_W'(BIN_LO);
  localparam logic [ADR_W-1:0] HI   = ADR_W'(BIN_HI);
  localparam logic [ADR_W-1:0] LAST = ADR_W'(NPTS - 1);

  state_e           state;
  logic [ADR_W-1:0] cnt;
  logic             drain_cnt;
  logic             prev_done;
  logic             start;
  logic             take;
  logic [ADR_W-1:0] tag_in;
  logic             s2_valid;
  mag_t             s2_mag;
  logic [ADR_W-1:0] s2_tag;
  mag_t             max_mag;
  logic [ADR_W-1:0] max_bin;

  assign start  = (state == ST_IDLE) && bus.fft_done && !prev_done;
  assign take   = start || ((state == ST_SCAN) && bus.fft_done);
  assign tag_in = start ? '0 : cnt;
  assign bus.busy = (state == ST_SCAN) || (state == ST_DRAIN) || (state == ST_REPORT);

  fft_mag_sq u_mag_sq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (take),
    .flush     (state == ST_ABORT),
    .sample    (bus.fft_wd),
    .tag_in    (tag_in),
    .out_valid (s2_valid),
    .mag       (s2_mag),
    .tag_out   (s2_tag)
  );

  // prev_done resets high so a done already asserted at release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      drain_cnt      <= 1'b0;
      prev_done      <= 1'b1;
      bus.peak_bin   <= '0;
      bus.peak_mag   <= '0;
      bus.peak_above <= 1'b0;
      bus.peak_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      prev_done      <= bus.fft_done;
      bus.peak_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SCAN;
            cnt   <= ADR_W'(1);
          end
        end
        ST_SCAN: begin
          if (!bus.fft_done) begin
            state <= ST_ABORT;
          end else if (cnt == LAST) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) state <= ST_REPORT;
          drain_cnt <= 1'b1;
        end
        ST_REPORT: begin
          bus.peak_bin   <= max_bin;
          bus.peak_mag   <= max_mag;
          bus.peak_above <= (max_mag >= bus.threshold);
          bus.peak_valid <= 1'b1;
          state          <= ST_WAIT_LOW;
        end
        ST_ABORT: begin
          bus.frame_err <= 1'b1;
          state         <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!bus.fft_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_mag <= '0;
      max_bin <= '0;
    end else if (start) begin
      max_mag <= '0;
      max_bin <= LO;
    end else if (s2_valid && (s2_tag >= LO) && (s2_tag <= HI) && (s2_mag > max_mag)) begin
      max_mag <= s2_mag;
      max_bin <= s2_tag;
    end
  end

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
- Downstream consumer of fft_controller: watches done/wd, streams the 64 complex bins through a squared-magnitude pipeline and finds the strongest bin in a configurable index window.
- Emits one peak report per FFT frame: bin index, magnitude and a threshold flag.
- Feeds the note/tone decision logic and the display path.

Parameters:
- BIN_LO, 1, lowest bin index searched (skips DC).
- BIN_HI, 31, highest bin index searched (inclusive; excludes mirrored half).
- NPTS, 64, FFT length; must equal fft_controller length.

Ports:
- clk  in  1  system clock, same domain as fft_controller.
- reset  in  1  asynchronous, active-high reset.
- fft_done  in  1  fft_controller done.
- fft_wd  in  32  fft_controller wd; [31:16] signed real, [15:0] signed imaginary.
- threshold  in  32  unsigned magnitude-squared threshold, sampled with each report.
- peak_bin  out  6  index of strongest bin in window.
- peak_mag  out  32  unsigned re²+im² of that bin.
- peak_above  out  1  peak_mag >= threshold.
- peak_valid  out  1  one-cycle pulse when the above outputs update.
- frame_err  out  1  one-cycle pulse when a frame aborts.
- busy  out  1  high while a frame is being scanned or drained.

Behaviour:
- Bin order is fixed: in fft_controller, bin k is on wd in the k-th cycle (from 0) of done being high, natural order.
- Reset values: peak_bin=0, peak_mag=0, peak_above=0, peak_valid=0, frame_err=0, busy=0. Internal counters, pipelines and running max are also cleared.
- FSM states:
  - IDLE: fft_done rising edge (done=1, previous done=0) → SCAN, bin counter=0, bin 0 sampled that cycle.
  - SCAN: sample fft_wd each cycle, counter increments.
    - Counter reaches NPTS-1 with done still high → DRAIN.
    - done falls before bin NPTS-1 → ABORT.
  - DRAIN: wait for pipeline empty (2 cycles) → REPORT.
  - REPORT: register outputs, pulse peak_valid → WAIT_LOW.
  - WAIT_LOW: remain until fft_done=0, then → IDLE. Done held high after the frame never retriggers.
  - ABORT: flush pipeline, pulse frame_err; no peak_valid; old peak outputs retained → WAIT_LOW (immediately IDLE, since done is already low).
- Magnitude pipeline, per bin, with the bin index tagged alongside:
  - Stage 1 registers re² and im² (each signed 16×16, unsigned 31 bits; max 2^30).
  - Stage 2 registers their sum, 32-bit unsigned; max 2^31, no overflow.
- Running max:
  - Updated from stage-2 output only if BIN_LO <= tag <= BIN_HI.
  - Strict greater-than compare, so ties keep the lowest index.
  - Initialised to mag 0, bin BIN_LO at start of each frame. An all-zero frame therefore reports bin BIN_LO, mag 0.
- Latency: peak_valid is high in the cycle after the 3rd rising edge following the edge that samples bin 63. It is high for exactly 1 cycle; outputs hold until the next report.
- peak_above is computed against threshold as sampled in the REPORT cycle.
- busy=1 in SCAN, DRAIN and REPORT; 0 otherwise.
- Asynchronous reset mid-frame: everything clears immediately. After release, a done already high is not treated as a rising edge, so the block waits for done to fall then rise again.

Decomposition:
- Shared package fft_pkg: NPTS, ADR_W=6, complex sample typedef (signed 16-bit re/im packed 32-bit), magnitude typedef (32-bit unsigned), FSM state enum.
- One sub-module: fft_mag_sq, the 2-stage re²+im² pipeline with tag passthrough.
- Peak FSM and compare stay in the top.

Test Plan:
- Single tone: bin 5 = 1000+j0, all other bins 0 → peak_valid once, peak_bin=5, peak_mag=1000000, peak_above=1 with threshold=999999.
- Tie: bins 3 and 7 both 0+j300 → peak_bin=3, peak_mag=90000.
- Out-of-window maxima: bin 0 = 20000, bin 40 = 20000, bin 10 = 100 (real) → peak_bin=10, peak_mag=10000.
- Full scale: bin 12 = -32768-j32768 → peak_mag=0x80000000, no overflow. An all-zero frame with threshold=1 → peak_bin=1, peak_mag=0, peak_above=0.
- Abort: done drops after bin 20 → frame_err pulses once, no peak_valid, previous outputs unchanged. The next full frame reports correctly.
- Reset at bin 30, released with done high → no report until done falls and rises. Check peak_valid timing is exactly 3 edges after bin 63.
